// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage load/store sequencer: bus handshake, lane steering, load extension, timeout
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_stall,
    output logic [31:0] o_mem_read_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        unsigned_q, unsigned_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        access;
    logic        misaligned_in;
    logic        start;
    logic        busy;
    logic        timeout_hit;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    assign access        = i_mem_read | i_mem_write;
    // Reserved size 2'b11 is checked like a word access.
    assign misaligned_in = ((i_size == SZ_HALF) && i_addr[0]) ||
                           (i_size[1] && (i_addr[1:0] != 2'b00));
    assign start         = (state_q == S_IDLE) && access && !misaligned_in;
    assign busy          = (state_q == S_BUSY);
    // A same-cycle ack always beats the timeout.
    assign timeout_hit   = busy && !i_bus_ack && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_BUSY;
            S_BUSY: if (i_bus_ack || timeout_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_shifted = i_bus_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: load_ext = unsigned_q ? {24'd0, rdata_shifted[7:0]}
                                           : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            SZ_HALF: load_ext = unsigned_q ? {16'd0, rdata_shifted[15:0]}
                                           : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        we_d       = we_q;
        unsigned_d = unsigned_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        if (start) begin
            addr_d     = i_addr;
            wdata_d    = i_wdata;
            size_d     = i_size;
            we_d       = i_mem_write;
            unsigned_d = i_unsigned;
            cnt_d      = 8'd0;
        end else if (busy) begin
            if (i_bus_ack) begin
                if (!we_q) rdata_d = load_ext;
            end else begin
                cnt_d = cnt_q + 8'd1;
                err_d = timeout_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'd0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            cnt_q      <= 8'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            we_q       <= we_d;
            unsigned_q <= unsigned_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Input-derived outputs are gated so nothing leaks out while reset is held.
    always_comb begin
        o_bus_req       = 1'b0;
        o_bus_we        = 1'b0;
        o_bus_addr      = 32'd0;
        o_bus_wdata     = 32'd0;
        o_bus_be        = 4'd0;
        o_stall         = 1'b0;
        o_misaligned    = 1'b0;
        o_bus_err       = err_q;
        o_mem_read_data = rdata_q;
        if (reset) begin
            o_stall      = start || busy;
            o_misaligned = (state_q == S_IDLE) && access && misaligned_in;
        end
        if (busy) begin
            o_bus_req  = 1'b1;
            o_bus_we   = we_q;
            o_bus_addr = {addr_q[31:2], 2'b00};
            case (size_q)
                SZ_BYTE: begin
                    o_bus_be    = 4'b0001 << addr_q[1:0];
                    o_bus_wdata = {4{wdata_q[7:0]}};
                end
                SZ_HALF: begin
                    o_bus_be    = 4'b0011 << {addr_q[1], 1'b0};
                    o_bus_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    o_bus_be    = 4'b1111;
                    o_bus_wdata = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_mem_read, i_mem_write;
    logic [31:0] i_addr, i_wdata;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_stall;
    logic [31:0] o_mem_read_data;
    logic        o_misaligned, o_bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size), .i_unsigned(i_unsigned),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
        .o_stall(o_stall), .o_mem_read_data(o_mem_read_data),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        i_mem_read  = rd;
        i_mem_write = wr;
        i_addr      = a;
        i_size      = sz;
        i_unsigned  = uns;
        i_wdata     = wd;
    endtask

    initial begin
        reset       = 1'b0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'd0;
        req(1'b1, 1'b0, 32'h100, 2'b10, 1'b0, 32'd0);

        // reset held with a request pending
        repeat (2) sample();
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_req", {31'd0, o_bus_req}, 32'd0);
        chk("rst_be", {28'd0, o_bus_be}, 32'd0);
        chk("rst_rdata", o_mem_read_data, 32'd0);
        chk("rst_misal", {31'd0, o_misaligned}, 32'd0);
        chk("rst_err", {31'd0, o_bus_err}, 32'd0);
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        reset = 1'b1;

        // word read 0x100, ack on first BUSY cycle
        drive_edge();
        req(1'b1, 1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
        sample();
        chk("wr_idle_stall", {31'd0, o_stall}, 32'd1);
        chk("wr_idle_req", {31'd0, o_bus_req}, 32'd0);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        i_bus_ack = 1'b1; i_bus_rdata = 32'hDEADBEEF;
        sample();
        chk("wr_busy_req", {31'd0, o_bus_req}, 32'd1);
        chk("wr_busy_stall", {31'd0, o_stall}, 32'd1);
        chk("wr_busy_be", {28'd0, o_bus_be}, 32'hF);
        chk("wr_busy_addr", o_bus_addr, 32'h100);
        chk("wr_busy_we", {31'd0, o_bus_we}, 32'd0);
        drive_edge();
        i_bus_ack = 1'b0;
        // DONE ignores a fresh request
        req(1'b1, 1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
        sample();
        chk("wr_done_stall", {31'd0, o_stall}, 32'd0);
        chk("wr_done_req", {31'd0, o_bus_req}, 32'd0);
        chk("wr_done_data", o_mem_read_data, 32'hDEADBEEF);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        sample();
        chk("wr_idle2_stall", {31'd0, o_stall}, 32'd0);
        chk("wr_idle2_req", {31'd0, o_bus_req}, 32'd0);

        // signed byte read 0x103
        drive_edge();
        req(1'b1, 1'b0, 32'h103, 2'b00, 1'b0, 32'd0);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        i_bus_ack = 1'b1; i_bus_rdata = 32'h80123456;
        sample();
        chk("sb_be", {28'd0, o_bus_be}, 32'h8);
        drive_edge();
        i_bus_ack = 1'b0;
        sample();
        chk("sb_data", o_mem_read_data, 32'hFFFFFF80);

        // unsigned byte read 0x103
        drive_edge();
        req(1'b1, 1'b0, 32'h103, 2'b00, 1'b1, 32'd0);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        i_bus_ack = 1'b1;
        drive_edge();
        i_bus_ack = 1'b0;
        sample();
        chk("ub_data", o_mem_read_data, 32'h00000080);

        // signed half read 0x102
        drive_edge();
        req(1'b1, 1'b0, 32'h102, 2'b01, 1'b0, 32'd0);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        i_bus_ack = 1'b1; i_bus_rdata = 32'h80017FFF;
        sample();
        chk("sh_be", {28'd0, o_bus_be}, 32'hC);
        drive_edge();
        i_bus_ack = 1'b0;
        sample();
        chk("sh_data", o_mem_read_data, 32'hFFFF8001);

        // half write 0x202; read and write both high -> write wins
        drive_edge();
        req(1'b1, 1'b1, 32'h202, 2'b01, 1'b0, 32'h0000ABCD);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        i_bus_ack = 1'b1; i_bus_rdata = 32'h55555555;
        sample();
        chk("hw_addr", o_bus_addr, 32'h200);
        chk("hw_be", {28'd0, o_bus_be}, 32'hC);
        chk("hw_wdata", o_bus_wdata, 32'hABCDABCD);
        chk("hw_we", {31'd0, o_bus_we}, 32'd1);
        drive_edge();
        i_bus_ack = 1'b0;
        sample();
        chk("hw_data_kept", o_mem_read_data, 32'hFFFF8001);

        // misaligned word read 0x101
        drive_edge();
        req(1'b1, 1'b0, 32'h101, 2'b10, 1'b0, 32'd0);
        sample();
        chk("ma_pulse", {31'd0, o_misaligned}, 32'd1);
        chk("ma_stall", {31'd0, o_stall}, 32'd0);
        chk("ma_req", {31'd0, o_bus_req}, 32'd0);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        sample();
        chk("ma_after", {31'd0, o_misaligned}, 32'd0);
        chk("ma_req2", {31'd0, o_bus_req}, 32'd0);

        // misaligned half read 0x101
        drive_edge();
        req(1'b1, 1'b0, 32'h101, 2'b01, 1'b0, 32'd0);
        sample();
        chk("mah_pulse", {31'd0, o_misaligned}, 32'd1);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);

        // ack with no access pending is ignored
        i_bus_ack = 1'b1; i_bus_rdata = 32'h12345678;
        drive_edge();
        i_bus_ack = 1'b0;
        sample();
        chk("idle_ack_data", o_mem_read_data, 32'hFFFF8001);
        chk("idle_ack_stall", {31'd0, o_stall}, 32'd0);

        // timeout: word read 0x300, ack withheld
        drive_edge();
        req(1'b1, 1'b0, 32'h300, 2'b10, 1'b0, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            drive_edge();
            req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
            sample();
            chk($sformatf("to_busy%0d_req", c), {31'd0, o_bus_req}, 32'd1);
            chk($sformatf("to_busy%0d_err", c), {31'd0, o_bus_err}, 32'd0);
        end
        drive_edge();
        sample();
        chk("to_err", {31'd0, o_bus_err}, 32'd1);
        chk("to_done_req", {31'd0, o_bus_req}, 32'd0);
        chk("to_done_stall", {31'd0, o_stall}, 32'd0);
        chk("to_data_kept", o_mem_read_data, 32'hFFFF8001);
        drive_edge();
        sample();
        chk("to_err_cleared", {31'd0, o_bus_err}, 32'd0);

        // ack on the fourth BUSY cycle wins over the timeout
        drive_edge();
        req(1'b1, 1'b0, 32'h300, 2'b10, 1'b0, 32'd0);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        repeat (3) drive_edge();
        i_bus_ack = 1'b1; i_bus_rdata = 32'h11223344;
        sample();
        chk("lack_req", {31'd0, o_bus_req}, 32'd1);
        drive_edge();
        i_bus_ack = 1'b0;
        sample();
        chk("lack_err", {31'd0, o_bus_err}, 32'd0);
        chk("lack_data", o_mem_read_data, 32'h11223344);
        drive_edge();

        // reset in the middle of BUSY
        drive_edge();
        req(1'b1, 1'b0, 32'h400, 2'b10, 1'b0, 32'd0);
        drive_edge();
        req(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
        sample();
        chk("mr_busy_req", {31'd0, o_bus_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_req_async", {31'd0, o_bus_req}, 32'd0);
        chk("mr_stall_async", {31'd0, o_stall}, 32'd0);
        chk("mr_data_cleared", o_mem_read_data, 32'd0);
        sample();
        reset = 1'b1;
        drive_edge();
        i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFEF00D;
        drive_edge();
        i_bus_ack = 1'b0;
        sample();
        chk("late_ack_data", o_mem_read_data, 32'd0);
        chk("late_ack_req", {31'd0, o_bus_req}, 32'd0);
        chk("late_ack_err", {31'd0, o_bus_err}, 32'd0);
        chk("late_ack_stall", {31'd0, o_stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for i_bus_ack before aborting (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports i_mem_read and i_mem_write, inputs, 1 bit each: access request from the EX/MEM register.
REQ-005 SHALL have port i_addr, input, 32 bits: byte address.
REQ-006 SHALL have port i_wdata, input, 32 bits: store data, right-aligned.
REQ-007 SHALL have port i_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 SHALL have port i_unsigned, input, 1 bit: 1 zero-extends loads, 0 sign-extends them.
REQ-009 SHALL have ports o_bus_req, o_bus_we, output, 1 bit each: bus request and write strobe.
REQ-010 SHALL have ports o_bus_addr (32 bits, word-aligned), o_bus_wdata (32 bits) and o_bus_be (4 bits), all outputs.
REQ-011 SHALL have ports i_bus_ack (input, 1 bit) and i_bus_rdata (input, 32 bits).
REQ-012 SHALL have port o_stall, output, 1 bit: freezes IF through EX/MEM while asserted.
REQ-013 SHALL have port o_mem_read_data, output, 32 bits: extended load result, feeding the MEM/WB register.
REQ-014 SHALL have ports o_misaligned and o_bus_err, outputs, 1 bit each: single-cycle exception pulses.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-016 In IDLE, an access occurs when i_mem_write or i_mem_read is high; i_mem_write has priority when both are high.
REQ-017 Misalignment SHALL be defined as: half with i_addr[0]=1, or word with i_addr[1:0]!=0.
REQ-018 A misaligned access in IDLE SHALL pulse o_misaligned for one cycle, keep o_stall low, issue no bus request, and remain in IDLE.
REQ-019 An aligned access in IDLE SHALL assert o_stall combinationally in the same cycle, latch address, size, type and data, and enter BUSY at the next edge.
REQ-020 In BUSY, o_bus_req SHALL be 1 and o_stall SHALL be 1.
REQ-021 In BUSY, o_bus_addr SHALL be {addr[31:2],2'b00}.
REQ-022 In BUSY, o_bus_be SHALL be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-023 In BUSY, o_bus_wdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-024 Bus address, data, enables and o_bus_we SHALL stay stable while o_bus_req=1.
REQ-025 When i_bus_ack=1 in BUSY, the block SHALL enter DONE at that edge and deassert o_bus_req.
REQ-026 On ack for a read, o_mem_read_data SHALL capture i_bus_rdata >> (8*addr[1:0]), truncated to the access size and then extended.
REQ-027 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-028 When the wait counter reaches TIMEOUT, the block SHALL pulse o_bus_err, enter DONE, and leave o_mem_read_data unchanged.
REQ-029 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win and o_bus_err SHALL stay low.
REQ-030 DONE SHALL last exactly one cycle with o_stall=0, ignore all inputs, and then return to IDLE; this prevents re-issuing the held instruction.
REQ-031 o_mem_read_data SHALL hold its value until the next completed read; writes and errors SHALL NOT alter it.
REQ-032 i_bus_ack outside BUSY SHALL be ignored.
REQ-033 Minimum aligned-access latency SHALL be 3 cycles: IDLE detect, BUSY with same-cycle ack, DONE.

Reset
REQ-034 While reset=0, the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-035 While reset=0, all outputs SHALL be 0, including o_mem_read_data, o_bus_be and o_stall.
REQ-036 Reset asserted mid-BUSY SHALL drop o_bus_req immediately, without waiting for a clock edge.
REQ-037 A late ack after reset SHALL be ignored.

Verification
REQ-038 Word read: addr 0x100, rdata 0xDEADBEEF, ack on the first BUSY cycle -> o_mem_read_data=0xDEADBEEF, o_stall high for exactly 2 cycles, o_bus_be=1111.
REQ-039 Signed byte read: addr 0x103, rdata 0x80123456, i_unsigned=0 -> o_mem_read_data=0xFFFFFF80, o_bus_be=1000; repeat with i_unsigned=1 -> 0x00000080.
REQ-040 Half write: addr 0x202, wdata 0x0000ABCD -> o_bus_addr=0x200, o_bus_be=1100, o_bus_wdata=0xABCDABCD, o_bus_we=1, o_mem_read_data unchanged.
REQ-041 Misaligned word read at 0x101 -> one-cycle o_misaligned, o_bus_req never asserted, o_stall=0.
REQ-042 Timeout: TIMEOUT=4, ack withheld -> o_bus_err pulses after 4 BUSY cycles, followed by DONE then IDLE; a second run with ack on cycle 4 -> no o_bus_err.
REQ-043 Reset mid-BUSY -> o_bus_req falls with reset; after release, an ack pulse produces no output change.
